// File: rtl/fc_pkg.sv
// fc_pkg: shared FSM encoding and arithmetic helpers for the fully connected layer sequencer
package fc_pkg;
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ISSUE = 3'd1,
        DRAIN = 3'd2,
        WRITE = 3'd3,
        DONE  = 3'd4
    } fc_state_e;

    function automatic int fc_acc_w(input int bitwidth, input int n_in);
        return 2 * bitwidth + $clog2(n_in) + 1;
    endfunction

    function automatic int fc_aw(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic logic signed [127:0] fc_shift_sat(input logic signed [255:0] acc, input int shift,
                                                         input int bw, input logic sat);
        logic signed [255:0] s;
        logic signed [255:0] hi;
        logic signed [255:0] lo;
        s  = acc >>> shift;
        hi = (256'sd1 <<< (bw - 1)) - 256'sd1;
        lo = -hi - 256'sd1;
        if (sat && s > hi) s = hi;
        else if (sat && s < lo) s = lo;
        return s[127:0];
    endfunction
endpackage

// File: rtl/fc_layer_sequencer_mac.sv
// fc_mac_unit: registered signed multiply-accumulate with synchronous clear and enable
module fc_mac_unit #(
    parameter int BW    = 32,
    parameter int ACC_W = 69
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic signed [BW-1:0]    a_i,
    input  logic signed [BW-1:0]    b_i,
    input  logic                    clr_i,
    input  logic                    en_i,
    output logic signed [ACC_W-1:0] acc_o
);
    logic signed [2*BW-1:0]  prod;
    logic signed [ACC_W-1:0] acc_q;
    logic signed [ACC_W-1:0] acc_d;

    assign prod  = (2 * BW)'(a_i) * (2 * BW)'(b_i);
    assign acc_d = clr_i ? '0 : en_i ? acc_q + ACC_W'(prod) : acc_q;
    assign acc_o = acc_q;

    // accumulator register; clear wins over enable
    always_ff @(posedge clk or posedge rst)
        if (rst) acc_q <= '0;
        else acc_q <= acc_d;
endmodule

// File: rtl/fc_layer_sequencer.sv
// fc_layer_sequencer: row-by-row FC layer controller driving one shared MAC and a valid/ready result port
module fc_layer_sequencer
    import fc_pkg::*;
#(
    parameter int BITWIDTH = 32,
    parameter int N_IN     = 10,
    parameter int N_OUT    = 10,
    parameter int SHIFT    = 32,
    parameter int SATURATE = 0
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            start_i,
    input  logic                            abort_i,
    output logic                            busy_o,
    output logic                            done_o,
    output logic                            rd_en_o,
    output logic [fc_aw(N_IN)-1:0]          x_addr_o,
    output logic [fc_aw(N_IN*N_OUT)-1:0]    w_addr_o,
    input  logic [BITWIDTH-1:0]             x_data_i,
    input  logic [BITWIDTH-1:0]             w_data_i,
    output logic                            out_valid_o,
    input  logic                            out_ready_i,
    output logic [fc_aw(N_OUT)-1:0]         out_idx_o,
    output logic [BITWIDTH-1:0]             out_data_o
);
    localparam int XW    = fc_aw(N_IN);
    localparam int WW    = fc_aw(N_IN * N_OUT);
    localparam int OW    = fc_aw(N_OUT);
    localparam int ACC_W = fc_acc_w(BITWIDTH, N_IN);

    localparam logic [2:0] S_IDLE  = IDLE;
    localparam logic [2:0] S_ISSUE = ISSUE;
    localparam logic [2:0] S_DRAIN = DRAIN;
    localparam logic [2:0] S_WRITE = WRITE;
    localparam logic [2:0] S_DONE  = DONE;

    logic [2:0]              state_q, state_d;
    logic [OW-1:0]           i_q, i_d;
    logic [XW-1:0]           j_q, j_d;
    logic [WW-1:0]           w_q, w_d;
    logic                    en_q, en_d;
    logic                    clr;
    logic                    last_i, last_j;
    logic signed [ACC_W-1:0] acc;
    logic [BITWIDTH-1:0]     y;

    assign last_j = j_q == XW'(N_IN - 1);
    assign last_i = i_q == OW'(N_OUT - 1);
    // read data lands one cycle after each issue, so the MAC enable is the issue strobe delayed
    assign en_d   = (state_q == S_ISSUE) && !abort_i;

    // next-state, counter and accumulator-clear decode; abort overrides everything
    always_comb begin
        state_d = state_q;
        i_d     = i_q;
        j_d     = j_q;
        w_d     = w_q;
        clr     = 1'b0;
        if (abort_i) begin
            state_d = S_IDLE;
            i_d     = '0;
            j_d     = '0;
            w_d     = '0;
            clr     = 1'b1;
        end else begin
            case (state_q)
                S_IDLE: if (start_i) begin
                    state_d = S_ISSUE;
                    i_d     = '0;
                    j_d     = '0;
                    w_d     = '0;
                    clr     = 1'b1;
                end
                S_ISSUE: begin
                    j_d     = last_j ? '0 : j_q + XW'(1);
                    w_d     = w_q + WW'(1);
                    state_d = last_j ? S_DRAIN : S_ISSUE;
                end
                S_DRAIN: state_d = S_WRITE;
                S_WRITE: if (out_ready_i) begin
                    clr     = 1'b1;
                    i_d     = last_i ? i_q : i_q + OW'(1);
                    state_d = last_i ? S_DONE : S_ISSUE;
                end
                S_DONE: begin
                    state_d = S_IDLE;
                    i_d     = '0;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // FSM state, row/column counters, running weight pointer and MAC enable
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            state_q <= S_IDLE;
            i_q     <= '0;
            j_q     <= '0;
            w_q     <= '0;
            en_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            i_q     <= i_d;
            j_q     <= j_d;
            w_q     <= w_d;
            en_q    <= en_d;
        end

    fc_mac_unit #(.BW(BITWIDTH), .ACC_W(ACC_W)) u_mac (
        .clk   (clk),
        .rst   (rst),
        .a_i   (x_data_i),
        .b_i   (w_data_i),
        .clr_i (clr),
        .en_i  (en_q),
        .acc_o (acc)
    );

    assign y           = BITWIDTH'(fc_shift_sat(256'(acc), SHIFT, BITWIDTH, SATURATE != 0));
    assign busy_o      = state_q inside {S_ISSUE, S_DRAIN, S_WRITE};
    assign done_o      = state_q == S_DONE;
    assign rd_en_o     = state_q == S_ISSUE;
    assign x_addr_o    = rd_en_o ? j_q : '0;
    assign w_addr_o    = rd_en_o ? w_q : '0;
    assign out_valid_o = state_q == S_WRITE;
    assign out_idx_o   = out_valid_o ? i_q : '0;
    assign out_data_o  = out_valid_o ? y : '0;
endmodule

// File: tb/tb_fc_layer_sequencer.sv
// tb_fc_layer_sequencer: directed scoreboard bench for the FC layer sequencer
module tb_fc_layer_sequencer;
    typedef struct packed {
        logic [3:0]  idx;
        logic [31:0] data;
    } exp_t;

    logic clk = 1'b0, rst = 1'b1, start = 1'b0, abort = 1'b0, out_ready = 1'b1, start_aux = 1'b0;
    int   n_chk = 0, n_pass = 0, cyc = 0, t0 = 0, ta = 0, done_cnt = 0, dc = 0;
    logic found;

    logic signed [31:0] x_mem [10];
    logic signed [31:0] w_mem [100];
    exp_t q_main[$], q_sat[$], q_raw[$], q_one[$];
    exp_t e_m, e_s, e_r, e_o;

    logic        busy, done, rd_en, out_valid;
    logic [3:0]  x_addr, out_idx;
    logic [6:0]  w_addr;
    logic [31:0] x_data, w_data, out_data;

    logic        s_busy, s_done, s_rd, s_valid;
    logic [3:0]  s_xa, s_idx;
    logic [6:0]  s_wa;
    logic [31:0] s_xd, s_wd, s_data;

    logic        r_busy, r_done, r_rd, r_valid;
    logic [3:0]  r_xa, r_idx;
    logic [6:0]  r_wa;
    logic [31:0] r_xd, r_wd, r_data;

    logic        o_busy, o_done, o_rd, o_valid;
    logic [0:0]  o_xa, o_idx, o_wa;
    logic [31:0] o_xd, o_wd, o_data;

    fc_layer_sequencer dut (
        .clk(clk), .rst(rst), .start_i(start), .abort_i(abort), .busy_o(busy), .done_o(done),
        .rd_en_o(rd_en), .x_addr_o(x_addr), .w_addr_o(w_addr), .x_data_i(x_data), .w_data_i(w_data),
        .out_valid_o(out_valid), .out_ready_i(out_ready), .out_idx_o(out_idx), .out_data_o(out_data)
    );

    fc_layer_sequencer #(.SHIFT(0), .SATURATE(1)) u_sat (
        .clk(clk), .rst(rst), .start_i(start_aux), .abort_i(1'b0), .busy_o(s_busy), .done_o(s_done),
        .rd_en_o(s_rd), .x_addr_o(s_xa), .w_addr_o(s_wa), .x_data_i(s_xd), .w_data_i(s_wd),
        .out_valid_o(s_valid), .out_ready_i(1'b1), .out_idx_o(s_idx), .out_data_o(s_data)
    );

    fc_layer_sequencer #(.SHIFT(0), .SATURATE(0)) u_raw (
        .clk(clk), .rst(rst), .start_i(start_aux), .abort_i(1'b0), .busy_o(r_busy), .done_o(r_done),
        .rd_en_o(r_rd), .x_addr_o(r_xa), .w_addr_o(r_wa), .x_data_i(r_xd), .w_data_i(r_wd),
        .out_valid_o(r_valid), .out_ready_i(1'b1), .out_idx_o(r_idx), .out_data_o(r_data)
    );

    fc_layer_sequencer #(.N_IN(1), .N_OUT(1), .SHIFT(0), .SATURATE(0)) u_one (
        .clk(clk), .rst(rst), .start_i(start_aux), .abort_i(1'b0), .busy_o(o_busy), .done_o(o_done),
        .rd_en_o(o_rd), .x_addr_o(o_xa), .w_addr_o(o_wa), .x_data_i(o_xd), .w_data_i(o_wd),
        .out_valid_o(o_valid), .out_ready_i(1'b1), .out_idx_o(o_idx), .out_data_o(o_data)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        if (rd_en)   begin x_data <= x_mem[x_addr]; w_data <= w_mem[w_addr]; end
        if (s_rd)    begin s_xd <= x_mem[s_xa];     s_wd <= w_mem[s_wa];     end
        if (r_rd)    begin r_xd <= x_mem[r_xa];     r_wd <= w_mem[r_wa];     end
        if (o_rd)    begin o_xd <= x_mem[o_xa];     o_wd <= w_mem[o_wa];     end
    end

    always @(negedge clk) if (done) done_cnt <= done_cnt + 1;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk = n_chk + 1;
        assert (obs === exp) n_pass = n_pass + 1;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    function automatic logic [31:0] gold(input int row);
        logic signed [127:0] s;
        s = '0;
        for (int j = 0; j < 10; j++) s += 128'(x_mem[j]) * 128'(w_mem[row * 10 + j]);
        s = s >>> 32;
        return s[31:0];
    endfunction

    always @(negedge clk) if (out_valid && out_ready) begin
        if (q_main.size() == 0) check("main_unexpected_out", 1, 0);
        else begin
            e_m = q_main.pop_front();
            check("main_idx", 64'(out_idx), 64'(e_m.idx));
            check("main_data", 64'(out_data), 64'(e_m.data));
        end
    end

    always @(negedge clk) begin
        if (s_valid) begin
            if (q_sat.size() == 0) check("sat_unexpected_out", 1, 0);
            else begin
                e_s = q_sat.pop_front();
                check("sat_idx", 64'(s_idx), 64'(e_s.idx));
                check("sat_data", 64'(s_data), 64'(e_s.data));
            end
        end
        if (r_valid) begin
            if (q_raw.size() == 0) check("raw_unexpected_out", 1, 0);
            else begin
                e_r = q_raw.pop_front();
                check("raw_idx", 64'(r_idx), 64'(e_r.idx));
                check("raw_data", 64'(r_data), 64'(e_r.data));
            end
        end
        if (o_valid) begin
            if (q_one.size() == 0) check("one_unexpected_out", 1, 0);
            else begin
                e_o = q_one.pop_front();
                check("one_idx", 64'(o_idx), 64'(e_o.idx));
                check("one_data", 64'(o_data), 64'(e_o.data));
            end
        end
    end

    task automatic set_identity();
        for (int i = 0; i < 10; i++) begin
            x_mem[i] = 32'(i * 65536);
            for (int j = 0; j < 10; j++) w_mem[i * 10 + j] = (i == j) ? 32'sd65536 : 32'sd0;
        end
    endtask

    task automatic set_fill(input logic signed [31:0] xv, input logic signed [31:0] wv);
        for (int i = 0; i < 10; i++) x_mem[i] = xv;
        for (int i = 0; i < 100; i++) w_mem[i] = wv;
    endtask

    task automatic launch_main();
        @(posedge clk);
        #1 start = 1'b1;
        t0 = cyc;
        for (int r = 0; r < 10; r++) q_main.push_back('{idx: 4'(r), data: gold(r)});
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int lat);
        for (int k = 0; k < 3000 && !done; k++) @(negedge clk);
        check(tag, 64'(cyc - t0), 64'(lat));
    endtask

    initial begin
        set_identity();
        @(negedge clk);
        check("reset_main_outputs", {busy, done, rd_en, out_valid, out_idx, x_addr, w_addr, out_data}, 0);
        check("reset_aux_outputs", {s_busy, s_done, s_rd, s_valid, s_data, o_busy, o_done, o_valid, o_data}, 0);
        @(negedge clk);
        rst = 1'b0;

        // identity weights: y[i] = i, done 121 cycles after start
        launch_main();
        check("busy_after_start", busy, 1);
        wait_done("identity_done_lat", 121);
        check("identity_busy_in_done", busy, 0);
        check("identity_queue_empty", q_main.size(), 0);

        // all products -2^32 -> y = -10
        set_fill(32'sd65536, -32'sd65536);
        launch_main();
        wait_done("neg_done_lat", 121);
        check("neg_queue_empty", q_main.size(), 0);

        // most negative x against most positive W
        set_fill(32'sh80000000, 32'sh7FFFFFFF);
        launch_main();
        wait_done("minmax_done_lat", 121);
        check("minmax_queue_empty", q_main.size(), 0);

        // saturating / wrapping instances with SHIFT=0, plus N_IN=N_OUT=1 instance
        set_fill(32'sh7FFFFFFF, 32'sh7FFFFFFF);
        @(posedge clk);
        #1 start_aux = 1'b1;
        ta = cyc;
        for (int r = 0; r < 10; r++) begin
            q_sat.push_back('{idx: 4'(r), data: 32'h7FFFFFFF});
            q_raw.push_back('{idx: 4'(r), data: 32'd10});
        end
        q_one.push_back('{idx: 4'd0, data: 32'd1});
        @(posedge clk);
        #1 start_aux = 1'b0;
        for (int k = 0; k < 20 && !o_done; k++) @(negedge clk);
        check("one_done_lat", 64'(cyc - ta), 4);
        for (int k = 0; k < 300 && !s_done; k++) @(negedge clk);
        check("sat_done_lat", 64'(cyc - ta), 121);
        check("raw_done_with_sat", r_done, 1);
        check("aux_queues_empty", q_sat.size() + q_raw.size() + q_one.size(), 0);

        // backpressure: hold row 3 for 5 cycles
        set_identity();
        launch_main();
        found = 1'b0;
        for (int k = 0; k < 500 && !found; k++) begin
            @(negedge clk);
            found = out_valid && out_idx == 4'd2;
        end
        check("bp_row2_seen", found, 1);
        @(posedge clk);
        #1 out_ready = 1'b0;
        found = 1'b0;
        for (int k = 0; k < 500 && !found; k++) begin
            @(negedge clk);
            found = out_valid;
        end
        check("bp_row3_seen", found, 1);
        for (int k = 0; k < 5; k++) begin
            check("bp_valid", out_valid, 1);
            check("bp_idx", out_idx, 3);
            check("bp_data", out_data, 3);
            check("bp_rd_en", rd_en, 0);
            @(posedge clk);
            #1 if (k == 4) out_ready = 1'b1;
            @(negedge clk);
        end
        wait_done("bp_done_lat", 126);
        check("bp_queue_empty", q_main.size(), 0);

        // abort in the middle of row 4
        launch_main();
        found = 1'b0;
        for (int k = 0; k < 500 && !found; k++) begin
            @(negedge clk);
            found = rd_en && w_addr == 7'd45;
        end
        check("abort_row4_seen", found, 1);
        dc = done_cnt;
        abort = 1'b1;
        @(posedge clk);
        #1 abort = 1'b0;
        check("abort_state", {busy, rd_en, out_valid, done}, 0);
        check("abort_rows_emitted", q_main.size(), 6);
        q_main.delete();
        repeat (40) @(negedge clk);
        check("abort_no_done", done_cnt - dc, 0);
        check("abort_stays_idle", busy, 0);

        // restart after abort gives the full vector
        launch_main();
        wait_done("restart_done_lat", 121);
        check("restart_queue_empty", q_main.size(), 0);

        // abort and start together in IDLE: nothing starts
        @(negedge clk);
        start = 1'b1;
        abort = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        abort = 1'b0;
        @(negedge clk);
        check("abort_beats_start", {busy, rd_en}, 0);

        // asynchronous reset in the middle of ISSUE
        launch_main();
        repeat (3) @(negedge clk);
        check("pre_reset_issuing", rd_en, 1);
        #2 rst = 1'b1;
        #1 check("async_reset_outputs", {busy, done, rd_en, out_valid, out_idx, x_addr, w_addr, out_data}, 0);
        q_main.delete();
        @(negedge clk);
        rst = 1'b0;

        // start while busy and in DONE is ignored
        dc = done_cnt;
        launch_main();
        repeat (30) @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        wait_done("ignore_start_done_lat", 121);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (150) @(negedge clk);
        check("single_done_pulse", done_cnt - dc, 1);
        check("idle_after_done", busy, 0);
        check("ignore_queue_empty", q_main.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
